// File: rtl/sine_meter_pkg.sv
// Shared definitions for the sine period meter: crossing-detector state encoding and defaults.
package sine_meter_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'b00,
        ST_PRIME = 2'b01,
        ST_HIGH  = 2'b10,
        ST_LOW   = 2'b11
    } state_e;

    localparam int DEF_PERIOD_W = 16;
    localparam int DEF_HYST     = 4;

endpackage

// File: rtl/sine_period_meter_sat_counter.sv
// Width-parameterised up-counter with synchronous load-to-one and a saturation flag.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load1,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max = &cnt_q;
    assign cnt    = cnt_q;

    // Load wins over enable; an enable at the ceiling holds the value.
    always_comb begin
        cnt_d = cnt_q;
        if (load1) begin
            cnt_d = {{(W-1){1'b0}}, 1'b1};
        end else if (en && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sine_period_meter.sv
// Measures period (in samples) and per-cycle peaks of a signed 8-bit stream via hysteretic rising crossings.
// Peak tracking is built only when SINE_PERIOD_METER_PEAK_EN is defined; otherwise peak_pos/peak_neg read 0.
module sine_period_meter
    import sine_meter_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int HYST     = DEF_HYST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [7:0]          sample,
    output logic [PERIOD_W-1:0] period,
    output logic [7:0]          peak_pos,
    output logic [7:0]          peak_neg,
    output logic                meas_valid,
    output logic                overflow,
    output logic                locked
);

    localparam logic signed [7:0] HYST_POS = 8'(HYST);
    localparam logic signed [7:0] HYST_NEG = -HYST_POS;

    logic signed [7:0] samp_s;
    logic              is_lo, is_hi;

    assign samp_s = sample;
    assign is_lo  = (samp_s <= HYST_NEG);
    assign is_hi  = (samp_s >= HYST_POS);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                meas_valid_q, meas_valid_d;
    logic                overflow_q, overflow_d;
    logic                locked_q, locked_d;

    logic                cnt_load, cnt_inc, cnt_at_max;
    logic [PERIOD_W-1:0] cnt;
    logic                peak_restart, peak_track, publish;

    sat_counter #(.W(PERIOD_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load1  (cnt_load),
        .en     (cnt_inc),
        .cnt    (cnt),
        .at_max (cnt_at_max)
    );

    always_comb begin
        state_d      = state_q;
        overflow_d   = overflow_q;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;
        peak_restart = 1'b0;
        peak_track   = 1'b0;
        publish      = 1'b0;
        if (sample_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (is_lo) state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    if (is_hi) begin
                        state_d      = ST_HIGH;
                        cnt_load     = 1'b1;
                        peak_restart = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_at_max) begin
                        overflow_d = 1'b1;
                        state_d    = ST_HUNT;
                    end else begin
                        cnt_inc    = 1'b1;
                        peak_track = 1'b1;
                        if (is_lo) state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    // The crossing sample closes the old cycle and opens the new one.
                    if (is_hi) begin
                        publish      = 1'b1;
                        cnt_load     = 1'b1;
                        peak_restart = 1'b1;
                        state_d      = ST_HIGH;
                    end else if (cnt_at_max) begin
                        overflow_d = 1'b1;
                        state_d    = ST_HUNT;
                    end else begin
                        cnt_inc    = 1'b1;
                        peak_track = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
        meas_valid_d = publish;
        period_d     = publish ? cnt : period_q;
        locked_d     = (state_d == ST_HIGH) || (state_d == ST_LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            overflow_q   <= overflow_d;
            locked_q     <= locked_d;
        end
    end

    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign overflow   = overflow_q;
    assign locked     = locked_q;

`ifdef SINE_PERIOD_METER_PEAK_EN
    logic signed [7:0] run_max_q, run_max_d, run_min_q, run_min_d;
    logic        [7:0] peak_pos_q, peak_pos_d, peak_neg_q, peak_neg_d;

    always_comb begin
        run_max_d  = run_max_q;
        run_min_d  = run_min_q;
        if (peak_restart) begin
            run_max_d = samp_s;
            run_min_d = samp_s;
        end else if (peak_track) begin
            if (samp_s > run_max_q) run_max_d = samp_s;
            if (samp_s < run_min_q) run_min_d = samp_s;
        end
        peak_pos_d = publish ? run_max_q : peak_pos_q;
        peak_neg_d = publish ? run_min_q : peak_neg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max_q  <= '0;
            run_min_q  <= '0;
            peak_pos_q <= '0;
            peak_neg_q <= '0;
        end else begin
            run_max_q  <= run_max_d;
            run_min_q  <= run_min_d;
            peak_pos_q <= peak_pos_d;
            peak_neg_q <= peak_neg_d;
        end
    end

    assign peak_pos = peak_pos_q;
    assign peak_neg = peak_neg_q;
`else
    logic unused_peak;
    assign unused_peak = ^{peak_restart, peak_track};
    assign peak_pos    = '0;
    assign peak_neg    = '0;
`endif

endmodule

// File: tb/tb_sine_period_meter.sv
// Bench for sine_period_meter: directed and random streams against a sample-level reference model.
module tb_sine_period_meter;

    localparam int PW     = 16;
    localparam int HY     = 4;
    localparam int PW_OVF = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic [7:0]    sample;
    logic [PW-1:0] period;
    logic [7:0]    peak_pos, peak_neg;
    logic          meas_valid, overflow, locked;

    logic              ovf_valid;
    logic [7:0]        ovf_sample;
    logic [PW_OVF-1:0] ovf_period;
    logic [7:0]        ovf_peak_pos, ovf_peak_neg;
    logic              ovf_meas_valid, ovf_overflow, ovf_locked;

    sine_period_meter #(.PERIOD_W(PW), .HYST(HY)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .period(period), .peak_pos(peak_pos), .peak_neg(peak_neg),
        .meas_valid(meas_valid), .overflow(overflow), .locked(locked)
    );

    sine_period_meter #(.PERIOD_W(PW_OVF), .HYST(HY)) dut_ovf (
        .clk(clk), .rst(rst), .sample_valid(ovf_valid), .sample(ovf_sample),
        .period(ovf_period), .peak_pos(ovf_peak_pos), .peak_neg(ovf_peak_neg),
        .meas_valid(ovf_meas_valid), .overflow(ovf_overflow), .locked(ovf_locked)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fail_cnt  = 0;
    int cyc       = 0;

    // Reference model: tracks crossings at the level of "armed / in a cycle / below zero".
    bit         m_armed, m_locked, m_below, m_ovf, m_mv;
    int         m_count, m_mx, m_mn;
    int         m_period;
    logic [7:0] m_pos, m_neg;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_locked = 0; m_below = 0; m_ovf = 0; m_mv = 0;
        m_count = 0; m_mx = 0; m_mn = 0; m_period = 0; m_pos = '0; m_neg = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input int s);
        bit lo, hi;
        lo = (s <= -HY);
        hi = (s >= HY);
        m_mv = 0;
        if (!m_locked) begin
            if (!m_armed) begin
                if (lo) m_armed = 1;
            end else if (hi) begin
                m_locked = 1; m_below = 0; m_count = 1; m_mx = s; m_mn = s;
            end
        end else if (m_below && hi) begin
            m_period = m_count;
            m_pos    = 8'(m_mx);
            m_neg    = 8'(m_mn);
            m_mv     = 1;
            exp_q.push_back(32'(m_count));
            m_count = 1; m_mx = s; m_mn = s; m_below = 0;
        end else if (m_count == (1 << PW) - 1) begin
            m_ovf = 1; m_locked = 0; m_armed = 0;
        end else begin
            m_count++;
            if (s > m_mx) m_mx = s;
            if (s < m_mn) m_mn = s;
            if (lo) m_below = 1;
        end
    endtask

    task automatic check_main();
        logic [7:0] e_pos, e_neg;
`ifdef SINE_PERIOD_METER_PEAK_EN
        e_pos = m_pos; e_neg = m_neg;
`else
        e_pos = '0; e_neg = '0;
`endif
        check("meas_valid", 32'(meas_valid), 32'(m_mv));
        check("locked", 32'(locked), 32'(m_locked));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("period", 32'(period), 32'(m_period));
        check("peak_pos", 32'(peak_pos), 32'(e_pos));
        check("peak_neg", 32'(peak_neg), 32'(e_neg));
        if (meas_valid) begin
            check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("sb_period", 32'(period), exp_q.pop_front());
        end
    endtask

    // Inputs are changed 1 time unit after the rising edge, outputs sampled at the same point.
    task automatic step(input bit v, input int s);
        sample_valid = v;
        sample       = 8'(s);
        @(posedge clk);
        cyc++;
        if (v) model_step(s);
        else   m_mv = 0;
        #1;
        check_main();
    endtask

    task automatic square(input int half, input int amp, input int periods, input bit gapped);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < 2 * half; i++) begin
                step(1'b1, (i < half) ? amp : -amp);
                if (gapped) step(1'b0, $urandom_range(0, 255) - 128);
            end
        end
    endtask

    task automatic ovf_step(input bit v, input int s, input bit e_ovf, input bit e_lock);
        ovf_valid  = v;
        ovf_sample = 8'(s);
        sample_valid = 1'b0;
        @(posedge clk);
        cyc++;
        m_mv = 0;
        #1;
        check("ovf_overflow", 32'(ovf_overflow), 32'(e_ovf));
        check("ovf_locked", 32'(ovf_locked), 32'(e_lock));
        check("ovf_meas_valid", 32'(ovf_meas_valid), 32'd0);
    endtask

    initial begin
        int last_pulse, pulses, half, amp, s;
        rst = 1'b1; sample_valid = 1'b0; sample = '0; ovf_valid = 1'b0; ovf_sample = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_main();
        check("ovf_reset_overflow", 32'(ovf_overflow), 32'd0);
        rst = 1'b0;

        // Dither inside the hysteresis band never arms the detector.
        for (int i = 0; i < 40; i++) step(1'b1, int'($urandom_range(0, 6)) - 3);
        check("dither_unlocked", 32'(locked), 32'd0);

        square(4, 50, 6, 1'b0);
        check("sq8_period", 32'(period), 32'd8);
        square(10, 100, 5, 1'b0);
        check("sq20_period", 32'(period), 32'd20);

        // Gapped stream: pulses must be 40 clocks apart.
        last_pulse = -1; pulses = 0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 20; i++) begin
                step(1'b1, (i < 10) ? 100 : -100);
                if (meas_valid) begin
                    if (last_pulse >= 0) check("gap_spacing", 32'(cyc - last_pulse), 32'd40);
                    last_pulse = cyc; pulses++;
                end
                step(1'b0, 0);
            end
        end
        check("gap_pulses", 32'(pulses), 32'd4);
        check("gap_period", 32'(period), 32'd20);

        // Asynchronous reset while in the low half of a cycle.
        for (int i = 0; i < 10; i++) step(1'b1, 100);
        for (int i = 0; i < 5; i++)  step(1'b1, -100);
        check("pre_rst_locked", 32'(locked), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_main();
        @(posedge clk);
        #2 rst = 1'b0;
        square(6, 70, 4, 1'b0);
        check("relock_period", 32'(period), 32'd12);

        // Triangle of period 256 standing in for the DDS loopback.
        for (int i = 0; i < 3 * 256 + 130; i++) begin
            s = i % 256;
            step(1'b1, (s < 128) ? (2 * s - 127) : (383 - 2 * s));
        end
        check("tri_period", 32'(period), 32'd256);
        check("tri_overflow", 32'(overflow), 32'd0);

        // Random squares with in-band noise and random valid gaps.
        for (int p = 0; p < 25; p++) begin
            half = $urandom_range(1, 30);
            amp  = $urandom_range(HY, 127);
            for (int i = 0; i < 2 * half; i++) begin
                if ($urandom_range(0, 7) == 0) step(1'b1, int'($urandom_range(0, 2 * HY - 2)) - (HY - 1));
                step(1'b1, (i < half) ? int'($urandom_range(HY, amp)) : -int'($urandom_range(HY, amp)));
                if ($urandom_range(0, 3) == 0) step(1'b0, $urandom_range(0, 255) - 128);
            end
        end
        // Fully random samples.
        for (int i = 0; i < 300; i++) step($urandom_range(0, 1), int'($urandom_range(0, 255)) - 128);

        // Saturation on the 4-bit instance: one lo, then 20 hi samples.
        ovf_step(1'b1, -50, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) ovf_step(1'b1, 60, k >= 16, k < 16);
        for (int i = 0; i < 30; i++) begin
            ovf_valid  = 1'b1;
            ovf_sample = 8'($urandom_range(0, 255));
            @(posedge clk);
            cyc++;
            #1;
            check("ovf_sticky", 32'(ovf_overflow), 32'd1);
        end
        ovf_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("ovf_cleared", 32'(ovf_overflow), 32'd0);
        check("ovf_rst_locked", 32'(ovf_locked), 32'd0);
        check_main();
        @(posedge clk);
        #2 rst = 1'b0;

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
